vid_pixel_stage: RTL

- Parametrised successor to the Gigatron video/clock glue.
- Turns the free-running 1-bit clock toggle into a glitch-free clock-enable generator.
- Expands N-bit per-channel colour to M-bit video, applies blanking and sync polarity, and registers outputs through a configurable pipeline.
- Adds raster position counters and a timing-lock detector, so the MiSTer video path and the Verilator SDL display both see stable, qualified pixels.

---
 rtl/vid_pixel_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vid_pixel_stage.sv
// Video pixel stage: clock-enable generator, colour expansion with blanking and
// sync polarity, output pipeline, raster position counters and line-lock detector.
module vid_pixel_stage #(
  parameter int unsigned CE_DIV     = 16,
  parameter int unsigned IN_BITS    = 2,
  parameter int unsigned OUT_BITS   = 8,
  parameter int unsigned PIPE       = 1,
  parameter int unsigned SYNC_INV   = 1,
  parameter int unsigned BLANK_ZERO = 1,
  parameter int unsigned LOCK_LINES = 3
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  output logic                ce_app,
  input  logic [IN_BITS-1:0]  red,
  input  logic [IN_BITS-1:0]  green,
  input  logic [IN_BITS-1:0]  blue,
  input  logic                hsync_n,
  input  logic                vsync_n,
  input  logic                hblank,
  input  logic                vblank,
  output logic [OUT_BITS-1:0] VGA_R,
  output logic [OUT_BITS-1:0] VGA_G,
  output logic [OUT_BITS-1:0] VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_HB,
  output logic                VGA_VB,
  output logic                ce_pix,
  output logic [10:0]         h_pos,
  output logic [9:0]          v_pos,
  output logic                locked
);

  localparam int unsigned CW  = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
  localparam int unsigned MW  = $clog2(LOCK_LINES + 1);
  localparam int unsigned REP = (OUT_BITS + IN_BITS - 1) / IN_BITS;
  localparam int unsigned CB  = 3 * OUT_BITS;
  localparam int unsigned PW  = CB + 25;

  localparam logic            SINV    = (SYNC_INV != 0);
  localparam logic            BZERO   = (BLANK_ZERO != 0);
  localparam logic [CW-1:0]   CE_LAST = CW'(CE_DIV - 1);
  localparam logic [MW-1:0]   LOCK_N  = MW'(LOCK_LINES);
  localparam logic [10:0]     H_MAX   = 11'h7FF;
  localparam logic [9:0]      V_MAX   = 10'h3FF;
  // Payload layout: {r, g, b, hs, vs, hb, vb, h_pos, v_pos}
  localparam logic [PW-1:0]   RST_V   = {{CB{1'b0}}, SINV, SINV, 2'b11, 21'd0};

  // MSB-first replication, keeping the top OUT_BITS bits.
  function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
    logic [REP*IN_BITS-1:0] rep;
    rep = {REP{c}};
    return rep[REP*IN_BITS-1 -: OUT_BITS];
  endfunction

  logic [CW-1:0]       ce_cnt;
  logic [PIPE:0]       ce_dly;
  logic                prev_hs_n;
  logic                prev_vs_n;
  logic [PW-1:0]       samp_q;
  logic [PW-1:0]       samp_d;
  logic [PW-1:0]       pipe_q [PIPE];
  logic [11:0]         len_q;
  logic [11:0]         len_d;
  logic [11:0]         line_len;
  logic [MW-1:0]       match_q;
  logic [MW-1:0]       match_d;
  logic                hs_fall;
  logic                vs_fall;
  logic                blank;
  logic [10:0]         h_cur;
  logic [10:0]         h_nxt;
  logic [9:0]          v_cur;
  logic [9:0]          v_nxt;
  logic [OUT_BITS-1:0] r_x;
  logic [OUT_BITS-1:0] g_x;
  logic [OUT_BITS-1:0] b_x;

  // Next sample-stage contents, raster counters and lock bookkeeping.
  always_comb begin
    hs_fall  = prev_hs_n & ~hsync_n;
    vs_fall  = prev_vs_n & ~vsync_n;
    h_cur    = samp_q[20:10];
    v_cur    = samp_q[9:0];
    h_nxt    = hs_fall ? 11'd0 : ((h_cur == H_MAX) ? h_cur : h_cur + 11'd1);
    v_nxt    = v_cur;
    if (vs_fall) begin
      v_nxt = 10'd0;
    end else if (hs_fall && v_cur != V_MAX) begin
      v_nxt = v_cur + 10'd1;
    end
    blank    = BZERO & (hblank | vblank);
    r_x      = blank ? '0 : expand(red);
    g_x      = blank ? '0 : expand(green);
    b_x      = blank ? '0 : expand(blue);
    samp_d   = {r_x, g_x, b_x, hsync_n ^ SINV, vsync_n ^ SINV, hblank, vblank, h_nxt, v_nxt};
    line_len = {1'b0, h_cur} + 12'd1;
    len_d    = len_q;
    match_d  = match_q;
    if (hs_fall) begin
      len_d = line_len;
      if (line_len == len_q) begin
        if (match_q != LOCK_N) match_d = match_q + MW'(1);
      end else begin
        match_d = '0;
      end
    end else if (h_nxt == H_MAX) begin
      match_d = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ce_cnt    <= '0;
      ce_app    <= 1'b0;
      ce_dly    <= '0;
      prev_hs_n <= 1'b0;
      prev_vs_n <= 1'b0;
      samp_q    <= RST_V;
      len_q     <= '0;
      match_q   <= '0;
      locked    <= 1'b0;
      for (int i = 0; i < int'(PIPE); i++) pipe_q[i] <= RST_V;
    end else begin
      ce_cnt <= (ce_cnt == CE_LAST) ? '0 : ce_cnt + CW'(1);
      ce_app <= (ce_cnt == CE_LAST);
      ce_dly <= {ce_dly[PIPE-1:0], ce_app};
      if (ce_app) begin
        prev_hs_n <= hsync_n;
        prev_vs_n <= vsync_n;
        samp_q    <= samp_d;
        len_q     <= len_d;
        match_q   <= match_d;
        locked    <= (match_d == LOCK_N);
      end
      // Output pipeline runs every cycle; data only moves after a sample.
      pipe_q[0] <= samp_q;
      for (int i = 1; i < int'(PIPE); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB, h_pos, v_pos} = pipe_q[PIPE-1];
  assign ce_pix = ce_dly[PIPE];

endmodule
